energy_best_tracker: RTL and testbench
======================================

Name: energy_best_tracker

Overview:
- Sits directly downstream of energy_monitor and consumes its energy_o/spin_o stream through a valid/ready handshake.
- Tracks the minimum energy seen in a run and the spin vector that produced it.
- Counts accepted samples and consecutive non-improving samples.
- Ends a run on a stall limit or a sample budget, then presents the best result through a result handshake until it is accepted.

Parameters:
ENERGY_TOTAL_BIT, 32, width of signed energy input/output (matches energy_monitor)
NUM_SPIN, 256, spin vector width
COUNT_BIT, 16, width of sample/stall counters and limit inputs

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
en_i  in  1  module enable; low freezes all state
clear_i  in  1  synchronous run abort/clear, highest priority
stall_limit_i  in  COUNT_BIT  consecutive non-improving samples that end a run; 0 disables
max_samples_i  in  COUNT_BIT  accepted-sample budget per run; 0 disables
energy_valid_i  in  1  upstream energy valid
energy_ready_o  out  1  tracker ready for a sample
energy_i  in  ENERGY_TOTAL_BIT  signed energy of sample
spin_i  in  NUM_SPIN  spin vector belonging to energy_i
best_valid_o  out  1  best_energy_o/best_spin_o hold a real sample
best_energy_o  out  ENERGY_TOTAL_BIT  signed running minimum
best_spin_o  out  NUM_SPIN  spin vector of the running minimum
sample_count_o  out  COUNT_BIT  samples accepted in current run
stall_count_o  out  COUNT_BIT  consecutive non-improving samples
improved_o  out  1  one-cycle pulse when best was replaced
result_valid_o  out  1  run finished, result stable
result_ready_i  in  1  consumer accepts result

Behaviour:
- Reset values:
  - All outputs are 0 and state is EMPTY.
  - energy_ready_o = 0 during reset.
- FSM states: EMPTY (no sample yet), TRACK, DONE.
- energy_ready_o = en_i && !clear_i && state!=DONE.
  - It has no combinational dependency on energy_valid_i.
  - Accept = energy_valid_i && energy_ready_o.
- All register updates appear on the cycle after acceptance. Latency is 1 cycle.
- Accept in EMPTY:
  - Sample is stored unconditionally and best_valid_o=1.
  - sample_count=1, stall=0, improved_o pulses.
  - Goes to TRACK, or to DONE if a termination check below fires.
- Accept in TRACK:
  - Comparison is signed and strict: energy_i < best_energy_o.
  - On improvement, the best is replaced, stall=0 and improved_o pulses.
  - On equal or greater energy, the best is kept (ties keep the earliest sample) and stall increments.
  - sample_count increments.
- Both counters saturate at all-ones and never wrap.
- Termination check is evaluated on post-update values at each acceptance:
  - (stall_limit_i!=0 && stall_next==stall_limit_i), or
  - (max_samples_i!=0 && count_next==max_samples_i).
  - If either holds, state becomes DONE in the same registered update.
  - Limits are sampled only at acceptance; changing them mid-run affects the next acceptance only.
- DONE:
  - result_valid_o = en_i; energy_ready_o = 0.
  - best_*, the counters and best_valid_o hold.
  - On result_valid_o && result_ready_i, go to EMPTY and zero all counters, best_valid_o, best_energy_o and best_spin_o.
- clear_i=1 (any state, en_i don't-care):
  - Next cycle is EMPTY with everything zeroed, same as a result handshake.
  - No sample is accepted in that cycle and improved_o stays 0.
- en_i=0: no acceptance and no state change. The result handshake is ignored and result_valid_o=0, but registered contents are retained.
- improved_o is high only for the cycle following an improving acceptance.
- Back-to-back acceptances, one per cycle, are supported at full throughput.
- Most-negative and most-positive energies are compared correctly. No arithmetic on energy beyond comparison.
- Reset asserted mid-run: immediate return to reset values, independent of clk_i.

Test Plan:
- Stream energies 10, 5, 7, 5, -3 (stall_limit=0, max_samples=0) -> best_energy_o sequence 10, 5, 5, 5, -3.
  - best_spin_o follows the samples with energies 10, 5, 5 (first), 5 (first), -3.
  - improved_o pulses on samples 1, 2 and 5; stall_count_o sequence 0, 0, 1, 2, 0.
- stall_limit=3, energies 4, 6, 6, 9 -> DONE after the 4th sample.
  - result_valid_o=1, best_energy_o=4, sample_count_o=4, stall_count_o=3.
  - energy_ready_o=0 while valid is held high.
- max_samples=2, energies -0x80000000, 0x7FFFFFFF -> DONE after the 2nd sample with best=-0x80000000.
  - Hold result_ready_i=0 for 5 cycles: outputs stable.
  - Then pulse result_ready_i: all outputs are 0 the next cycle and energy_ready_o=1.
- Mid-TRACK: assert clear_i in the same cycle as energy_valid_i with energy 1 -> sample not accepted, next cycle EMPTY with best_valid_o=0.
  - The next sample (energy 50) is accepted unconditionally as best.
- Drop en_i for 3 cycles while valid=1 -> energy_ready_o=0 and no counter change.
  - In DONE, result_valid_o=0 and result_ready_i=1 is ignored.
  - Restoring en_i resumes with identical contents.
- Assert rst_ni low asynchronously in the middle of a DONE state -> all outputs 0 immediately.
  - After release, the first sample is accepted as best with sample_count_o=1.

Source files
------------

// File: rtl/energy_best_tracker.sv
// Running-minimum tracker over the energy_monitor output stream.
// Keeps the lowest energy and its spin vector per run and presents them once a stall or sample budget ends the run.
module energy_best_tracker #(
    parameter int ENERGY_TOTAL_BIT = 32,
    parameter int NUM_SPIN         = 256,
    parameter int COUNT_BIT        = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic                        clear_i,
    input  logic [COUNT_BIT-1:0]        stall_limit_i,
    input  logic [COUNT_BIT-1:0]        max_samples_i,
    input  logic                        energy_valid_i,
    output logic                        energy_ready_o,
    input  logic [ENERGY_TOTAL_BIT-1:0] energy_i,
    input  logic [NUM_SPIN-1:0]         spin_i,
    output logic                        best_valid_o,
    output logic [ENERGY_TOTAL_BIT-1:0] best_energy_o,
    output logic [NUM_SPIN-1:0]         best_spin_o,
    output logic [COUNT_BIT-1:0]        sample_count_o,
    output logic [COUNT_BIT-1:0]        stall_count_o,
    output logic                        improved_o,
    output logic                        result_valid_o,
    input  logic                        result_ready_i
);

    typedef enum logic [1:0] {EMPTY, TRACK, DONE} state_t;

    localparam logic [COUNT_BIT-1:0] CNT_ONE = COUNT_BIT'(1);

    state_t                      r_state, w_state_next;
    logic                        r_best_valid, w_best_valid_next;
    logic [ENERGY_TOTAL_BIT-1:0] r_best_energy, w_best_energy_next;
    logic [NUM_SPIN-1:0]         r_best_spin, w_best_spin_next;
    logic [COUNT_BIT-1:0]        r_sample_cnt, w_sample_cnt_next;
    logic [COUNT_BIT-1:0]        r_stall_cnt, w_stall_cnt_next;
    logic                        r_improved, w_improved_next;
    logic                        w_accept, w_better, w_done_hit;
    logic [COUNT_BIT-1:0]        w_sample_inc, w_stall_inc;

    // rst_ni in the path keeps ready low while reset is held, whatever en_i does
    assign energy_ready_o = rst_ni && en_i && !clear_i && (r_state != DONE);
    assign w_accept       = energy_valid_i && energy_ready_o;
    assign w_better       = (r_state == EMPTY) ||
                            ($signed(energy_i) < $signed(r_best_energy));
    assign w_sample_inc   = (r_sample_cnt == '1) ? r_sample_cnt : r_sample_cnt + CNT_ONE;
    assign w_stall_inc    = (r_stall_cnt  == '1) ? r_stall_cnt  : r_stall_cnt  + CNT_ONE;

    always_comb begin
        w_state_next       = r_state;
        w_best_valid_next  = r_best_valid;
        w_best_energy_next = r_best_energy;
        w_best_spin_next   = r_best_spin;
        w_sample_cnt_next  = r_sample_cnt;
        w_stall_cnt_next   = r_stall_cnt;
        w_improved_next    = 1'b0;
        w_done_hit         = 1'b0;

        if (clear_i || (en_i && r_state == DONE && result_ready_i)) begin
            w_state_next       = EMPTY;
            w_best_valid_next  = 1'b0;
            w_best_energy_next = '0;
            w_best_spin_next   = '0;
            w_sample_cnt_next  = '0;
            w_stall_cnt_next   = '0;
        end else if (w_accept) begin
            w_best_valid_next = 1'b1;
            w_sample_cnt_next = (r_state == EMPTY) ? CNT_ONE : w_sample_inc;
            if (w_better) begin
                w_best_energy_next = energy_i;
                w_best_spin_next   = spin_i;
                w_stall_cnt_next   = '0;
                w_improved_next    = 1'b1;
            end else begin
                w_stall_cnt_next   = w_stall_inc;
            end
            // limits are judged against the values this acceptance produces
            w_done_hit = ((stall_limit_i != '0) && (w_stall_cnt_next  == stall_limit_i)) ||
                         ((max_samples_i != '0) && (w_sample_cnt_next == max_samples_i));
            w_state_next = w_done_hit ? DONE : TRACK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= EMPTY;
            r_best_valid  <= 1'b0;
            r_best_energy <= '0;
            r_best_spin   <= '0;
            r_sample_cnt  <= '0;
            r_stall_cnt   <= '0;
            r_improved    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_best_valid  <= w_best_valid_next;
            r_best_energy <= w_best_energy_next;
            r_best_spin   <= w_best_spin_next;
            r_sample_cnt  <= w_sample_cnt_next;
            r_stall_cnt   <= w_stall_cnt_next;
            r_improved    <= w_improved_next;
        end
    end

    assign best_valid_o   = r_best_valid;
    assign best_energy_o  = r_best_energy;
    assign best_spin_o    = r_best_spin;
    assign sample_count_o = r_sample_cnt;
    assign stall_count_o  = r_stall_cnt;
    assign improved_o     = r_improved;
    assign result_valid_o = en_i && (r_state == DONE);

endmodule

// File: tb/tb_energy_best_tracker.sv
// Scenario bench for energy_best_tracker: expected output snapshots are queued as stimulus is driven, popped one cycle later.
module tb_energy_best_tracker;
    localparam int EB = 32;
    localparam int NS = 256;
    localparam int CB = 16;

    logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0, ev = 1'b0, rr = 1'b0;
    logic [CB-1:0] sl = '0, ms = '0;
    logic [EB-1:0] e = '0;
    logic [NS-1:0] sp = '0;
    logic          e_rdy, bv, imp, rv;
    logic [EB-1:0] be;
    logic [NS-1:0] bs;
    logic [CB-1:0] sc, st;

    energy_best_tracker #(.ENERGY_TOTAL_BIT(EB), .NUM_SPIN(NS), .COUNT_BIT(CB)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clr),
        .stall_limit_i(sl), .max_samples_i(ms),
        .energy_valid_i(ev), .energy_ready_o(e_rdy), .energy_i(e), .spin_i(sp),
        .best_valid_o(bv), .best_energy_o(be), .best_spin_o(bs),
        .sample_count_o(sc), .stall_count_o(st), .improved_o(imp),
        .result_valid_o(rv), .result_ready_i(rr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          bv;
        logic [EB-1:0] be;
        logic [NS-1:0] bs;
        logic [CB-1:0] sc;
        logic [CB-1:0] st;
        logic          imp;
        logic          rv;
    } snap_t;

    snap_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    localparam snap_t ZERO = '0;

    function automatic logic [NS-1:0] mk_spin(input int k);
        logic [NS-1:0] v;
        for (int i = 0; i < NS / 32; i++) v[i*32 +: 32] = 32'(k) * 32'h9E3779B9 + 32'(i);
        return v;
    endfunction

    function automatic snap_t mk(input logic b, input logic [EB-1:0] en_v, input logic [NS-1:0] s,
                                 input int c, input int t, input logic i, input logic r);
        snap_t x;
        x = '{b, en_v, s, CB'(c), CB'(t), i, r};
        return x;
    endfunction

    function automatic snap_t obs();
        snap_t x;
        x = '{bv, be, bs, sc, st, imp, rv};
        return x;
    endfunction

    task automatic test_reset();
        snap_t w;
        rst_n = 1'b0; en = 1'b1; ev = 1'b1; e = 32'd3; sp = mk_spin(99);
        #1;
        n_tests++;
        if (e_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", e_rdy); end
        w = obs();
        n_tests++;
        if (w !== ZERO) begin n_fail++; $display("FAIL reset_outputs got=%h want=%h", w, ZERO); end
        @(negedge clk);
        rst_n = 1'b1; ev = 1'b0;
    endtask

    task automatic test_stream();
        logic [EB-1:0] ens[5] = '{32'd10, 32'd5, 32'd7, 32'd5, -32'sd3};
        int            bidx[5] = '{0, 1, 1, 1, 4};
        int            stl[5] = '{0, 0, 1, 2, 0};
        logic          imps[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        snap_t w, x;
        sl = '0; ms = '0;
        for (int i = 0; i < 5; i++) begin
            ev = 1'b1; e = ens[i]; sp = mk_spin(10 + i);
            q.push_back(mk(1'b1, ens[bidx[i]], mk_spin(10 + bidx[i]), i + 1, stl[i], imps[i], 1'b0));
            #1;
            n_tests++;
            if (e_rdy !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got=%b want=1", i, e_rdy); end
            @(negedge clk);
            x = q.pop_front(); w = obs();
            n_tests++;
            if (w !== x) begin n_fail++; $display("FAIL stream[%0d] got=%h want=%h", i, w, x); end
        end
        ev = 1'b0;
    endtask

    task automatic test_clear();
        snap_t w, x;
        ev = 1'b1; e = 32'd1; sp = mk_spin(1); clr = 1'b1;
        q.push_back(ZERO);
        #1;
        n_tests++;
        if (e_rdy !== 1'b0) begin n_fail++; $display("FAIL clear_ready got=%b want=0", e_rdy); end
        @(negedge clk);
        x = q.pop_front(); w = obs();
        n_tests++;
        if (w !== x) begin n_fail++; $display("FAIL clear_zero got=%h want=%h", w, x); end
        clr = 1'b0; e = 32'd50; sp = mk_spin(50);
        q.push_back(mk(1'b1, 32'd50, mk_spin(50), 1, 0, 1'b1, 1'b0));
        @(negedge clk);
        x = q.pop_front(); w = obs();
        n_tests++;
        if (w !== x) begin n_fail++; $display("FAIL clear_next got=%h want=%h", w, x); end
        ev = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_stall_limit();
        logic [EB-1:0] ens[4] = '{32'd4, 32'd6, 32'd6, 32'd9};
        snap_t w, x;
        sl = CB'(3); ms = '0;
        for (int i = 0; i < 4; i++) begin
            ev = 1'b1; e = ens[i]; sp = mk_spin(20 + i);
            q.push_back(mk(1'b1, 32'd4, mk_spin(20), i + 1, i, i == 0, i == 3));
            @(negedge clk);
            x = q.pop_front(); w = obs();
            n_tests++;
            if (w !== x) begin n_fail++; $display("FAIL stall[%0d] got=%h want=%h", i, w, x); end
        end
        e = -32'sd5; sp = mk_spin(29);
        q.push_back(mk(1'b1, 32'd4, mk_spin(20), 4, 3, 1'b0, 1'b1));
        #1;
        n_tests++;
        if (e_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_done_ready got=%b want=0", e_rdy); end
        @(negedge clk);
        x = q.pop_front(); w = obs();
        n_tests++;
        if (w !== x) begin n_fail++; $display("FAIL stall_hold got=%h want=%h", w, x); end
        ev = 1'b0; rr = 1'b1;
        q.push_back(ZERO);
        @(negedge clk);
        rr = 1'b0;
        x = q.pop_front(); w = obs();
        n_tests++;
        if (w !== x || e_rdy !== 1'b1) begin
            n_fail++; $display("FAIL stall_handshake got=%h rdy=%b want=%h rdy=1", w, e_rdy, x);
        end
        sl = '0;
    endtask

    task automatic test_max_samples();
        logic [EB-1:0] ens[2] = '{32'h8000_0000, 32'h7FFF_FFFF};
        snap_t w, x;
        ms = CB'(2);
        for (int i = 0; i < 2; i++) begin
            ev = 1'b1; e = ens[i]; sp = mk_spin(30 + i);
            q.push_back(mk(1'b1, 32'h8000_0000, mk_spin(30), i + 1, i, i == 0, i == 1));
            @(negedge clk);
            x = q.pop_front(); w = obs();
            n_tests++;
            if (w !== x) begin n_fail++; $display("FAIL max[%0d] got=%h want=%h", i, w, x); end
        end
        ev = 1'b0;
        for (int i = 0; i < 5; i++) begin
            q.push_back(mk(1'b1, 32'h8000_0000, mk_spin(30), 2, 1, 1'b0, 1'b1));
            @(negedge clk);
            x = q.pop_front(); w = obs();
            n_tests++;
            if (w !== x) begin n_fail++; $display("FAIL max_hold[%0d] got=%h want=%h", i, w, x); end
        end
        rr = 1'b1;
        q.push_back(ZERO);
        @(negedge clk);
        rr = 1'b0;
        x = q.pop_front(); w = obs();
        n_tests++;
        if (w !== x || e_rdy !== 1'b1) begin
            n_fail++; $display("FAIL max_handshake got=%h rdy=%b want=%h rdy=1", w, e_rdy, x);
        end
        ms = '0;
    endtask

    task automatic test_enable();
        snap_t w, x;
        ev = 1'b1; e = 32'd20; sp = mk_spin(40);
        q.push_back(mk(1'b1, 32'd20, mk_spin(40), 1, 0, 1'b1, 1'b0));
        @(negedge clk);
        x = q.pop_front(); w = obs();
        n_tests++;
        if (w !== x) begin n_fail++; $display("FAIL en_first got=%h want=%h", w, x); end
        en = 1'b0; e = -32'sd100; sp = mk_spin(41);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin en = 1'b1; ev = 1'b0; end
            q.push_back(mk(1'b1, 32'd20, mk_spin(40), 1, 0, 1'b0, 1'b0));
            #1;
            n_tests++;
            if (e_rdy !== (i == 3)) begin n_fail++; $display("FAIL en_ready[%0d] got=%b want=%b", i, e_rdy, i == 3); end
            @(negedge clk);
            x = q.pop_front(); w = obs();
            n_tests++;
            if (w !== x) begin n_fail++; $display("FAIL en_freeze[%0d] got=%h want=%h", i, w, x); end
        end
        ms = CB'(2); ev = 1'b1; e = 32'd30; sp = mk_spin(42);
        q.push_back(mk(1'b1, 32'd20, mk_spin(40), 2, 1, 1'b0, 1'b1));
        @(negedge clk);
        ev = 1'b0;
        x = q.pop_front(); w = obs();
        n_tests++;
        if (w !== x) begin n_fail++; $display("FAIL en_done got=%h want=%h", w, x); end
        en = 1'b0; rr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin en = 1'b1; rr = 1'b0; end
            q.push_back(mk(1'b1, 32'd20, mk_spin(40), 2, 1, 1'b0, i == 3));
            @(negedge clk);
            x = q.pop_front(); w = obs();
            n_tests++;
            if (w !== x) begin n_fail++; $display("FAIL en_done_hold[%0d] got=%h want=%h", i, w, x); end
        end
        rr = 1'b1;
        q.push_back(ZERO);
        @(negedge clk);
        rr = 1'b0; ms = '0;
        x = q.pop_front(); w = obs();
        n_tests++;
        if (w !== x) begin n_fail++; $display("FAIL en_handshake got=%h want=%h", w, x); end
    endtask

    task automatic test_async_reset();
        snap_t w, x;
        ms = CB'(1); ev = 1'b1; e = 32'd77; sp = mk_spin(77);
        q.push_back(mk(1'b1, 32'd77, mk_spin(77), 1, 0, 1'b1, 1'b1));
        @(negedge clk);
        ev = 1'b0;
        x = q.pop_front(); w = obs();
        n_tests++;
        if (w !== x) begin n_fail++; $display("FAIL arst_done got=%h want=%h", w, x); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        w = obs();
        n_tests++;
        if (w !== ZERO || e_rdy !== 1'b0) begin
            n_fail++; $display("FAIL arst_immediate got=%h rdy=%b want=%h rdy=0", w, e_rdy, ZERO);
        end
        @(negedge clk);
        rst_n = 1'b1; ms = '0; ev = 1'b1; e = 32'd88; sp = mk_spin(88);
        q.push_back(mk(1'b1, 32'd88, mk_spin(88), 1, 0, 1'b1, 1'b0));
        @(negedge clk);
        ev = 1'b0;
        x = q.pop_front(); w = obs();
        n_tests++;
        if (w !== x) begin n_fail++; $display("FAIL arst_after got=%h want=%h", w, x); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_clear();
        test_stall_limit();
        test_max_samples();
        test_enable();
        test_async_reset();
        n_tests++;
        if (q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d want=0", q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
